// File: rtl/upcoin_sha_pkg.sv
// Shared constants and round primitives for the uPcoin SHA-256 stream core.
package upcoin_sha_pkg;

    typedef logic [1:0] sha_state_t;

    localparam sha_state_t StIdle  = 2'd0;
    localparam sha_state_t StRound = 2'd1;
    localparam sha_state_t StFinal = 2'd2;
    localparam sha_state_t StOut   = 2'd3;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; working variables packed a (MSB) .. h (LSB).
module sha256_round
    import upcoin_sha_pkg::*;
(
    input  logic [255:0] state_i,
    input  logic [31:0]  w_i,
    input  logic [31:0]  k_i,
    output logic [255:0] state_o
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_i;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// SHA-256 block engine: chains H across framed blocks, R rounds per clock, registered digest out.
module sha256_stream_core
    import upcoin_sha_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          MIDSTATE_EN      = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         iv_sel,
    input  logic [255:0] iv_in,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int         R     = int'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] TLast = 6'(64 - R);

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    sha_state_t         state_q, state_d;
    logic [5:0]         t_q, t_d;
    logic [15:0][31:0]  w_q, w_d;
    logic [255:0]       v_q, v_d;
    logic [255:0]       h_q, h_d;
    logic [255:0]       digest_q, digest_d;
    logic               last_q, last_d;

    // wx[0..15] is the live window; wx[16..] are the R words appended this cycle.
    logic [31:0] wx [16 + R];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            wx[i] = w_q[i];
        end
        for (int i = 16; i < 16 + R; i++) begin
            wx[i] = small_sigma1(wx[i - 2]) + wx[i - 7] + small_sigma0(wx[i - 15]) + wx[i - 16];
        end
    end

    for (genvar r = 0; r < R; r++) begin : g_round
        logic [255:0] st_in, st_out;
        if (r == 0) begin : g_head
            assign st_in = v_q;
        end else begin : g_link
            assign st_in = g_round[r - 1].st_out;
        end
        sha256_round u_round (
            .state_i (st_in),
            .w_i     (wx[r]),
            .k_i     (SHA256_K[t_q + 6'(r)]),
            .state_o (st_out)
        );
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        w_d      = w_q;
        v_d      = v_q;
        h_d      = h_q;
        last_d   = last_q;
        digest_d = digest_q;
        case (state_q)
            StIdle: begin
                if (blk_valid) begin
                    if (blk_first) begin
                        h_d = (MIDSTATE_EN && iv_sel) ? iv_in : SHA256_IV;
                    end
                    v_d = h_d;
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk_data[511 - 32 * i -: 32];
                    end
                    last_d  = blk_last;
                    t_d     = '0;
                    state_d = StRound;
                end
            end
            StRound: begin
                v_d = g_round[R - 1].st_out;
                for (int i = 0; i < 16; i++) begin
                    w_d[i] = wx[i + R];
                end
                t_d = t_q + 6'(R);
                if (t_q == TLast) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[32 * i +: 32] = h_q[32 * i +: 32] + v_q[32 * i +: 32];
                end
                if (last_q) begin
                    digest_d = h_d;
                    state_d  = StOut;
                end else begin
                    state_d = StIdle;
                end
            end
            StOut: begin
                if (digest_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            t_q      <= '0;
            w_q      <= '0;
            v_q      <= '0;
            h_q      <= SHA256_IV;
            digest_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            w_q      <= w_d;
            v_q      <= v_d;
            h_q      <= h_d;
            digest_q <= digest_d;
            last_q   <= last_d;
        end
    end

    assign blk_ready    = (state_q == StIdle);
    assign digest_valid = (state_q == StOut);
    assign busy         = (state_q != StIdle);
    assign digest       = digest_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Drives three core configurations in lock-step and checks them against a plain SHA-256 model.
module tb_sha256_stream_core;

    localparam int ND = 3;
    localparam int RPC [ND]  = '{1, 2, 4};
    localparam bit MIDS [ND] = '{1'b1, 1'b0, 1'b1};

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_M1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          blk_valid, blk_first, blk_last, iv_sel, digest_ready;
    logic [511:0]  blk_data;
    logic [255:0]  iv_in;
    logic [ND-1:0] blk_ready, digest_valid, busy;
    logic [255:0]  digest [ND];

    int           vectors = 0;
    int           errors  = 0;
    logic [255:0] mh [ND];
    int           lat [ND];
    bit           rdy_low [ND];

    always #5 clk = ~clk;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        sha256_stream_core #(
            .ROUNDS_PER_CYCLE (RPC[i]),
            .MIDSTATE_EN      (MIDS[i])
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .blk_valid    (blk_valid),
            .blk_ready    (blk_ready[i]),
            .blk_data     (blk_data),
            .blk_first    (blk_first),
            .blk_last     (blk_last),
            .iv_sel       (iv_sel),
            .iv_in        (iv_in),
            .digest_valid (digest_valid[i]),
            .digest_ready (digest_ready),
            .digest       (digest[i]),
            .busy         (busy[i])
        );
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + v[i];
        return hout;
    endfunction

    // Offers one block, updates the model chain, and records per-DUT cycles (acceptance cycle = 0)
    // until the digest appears (last) or blk_ready returns (not last).
    task automatic run_block(input bit first, input bit last, input logic [511:0] data,
                             input bit sel, input logic [255:0] iv);
        bit all_done;
        blk_data = data; blk_first = first; blk_last = last; iv_sel = sel; iv_in = iv;
        blk_valid = 1'b1;
        for (int k = 0; k < 300 && blk_ready != '1; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; iv_sel = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (first) mh[i] = (sel && MIDS[i]) ? iv : IV;
            mh[i]      = compress(mh[i], data);
            lat[i]     = -1;
            rdy_low[i] = 1'b1;
        end
        for (int cyc = 1; cyc < 300; cyc++) begin
            all_done = 1'b1;
            for (int i = 0; i < ND; i++) begin
                if (lat[i] < 0) begin
                    if (last ? digest_valid[i] : blk_ready[i]) begin
                        lat[i] = cyc;
                    end else begin
                        if (blk_ready[i]) rdy_low[i] = 1'b0;
                        all_done = 1'b0;
                    end
                end
            end
            if (all_done) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic pop_digest();
        digest_ready = 1'b1;
        @(posedge clk); #1;
        digest_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if ({blk_ready[i], digest_valid[i], busy[i]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_flags dut%0d: got rdy/dv/busy=%b want 100", i,
                         {blk_ready[i], digest_valid[i], busy[i]});
            end
            vectors++;
            if (digest[i] !== 256'h0) begin
                errors++;
                $display("FAIL reset_digest dut%0d: got %h want 0", i, digest[i]);
            end
            mh[i] = IV;
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        run_block(1'b1, 1'b1, BLK_ABC, 1'b0, '0);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (lat[i] !== 64 / RPC[i] + 2) begin
                errors++;
                $display("FAIL abc_latency dut%0d: got %0d want %0d", i, lat[i], 64 / RPC[i] + 2);
            end
            vectors++;
            if (rdy_low[i] !== 1'b1) begin
                errors++;
                $display("FAIL abc_ready_low dut%0d: got ready seen high want low", i);
            end
            vectors++;
            if (digest[i] !== DIG_ABC) begin
                errors++;
                $display("FAIL abc_digest dut%0d: got %h want %h", i, digest[i], DIG_ABC);
            end
        end
        pop_digest();
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if ({digest_valid[i], blk_ready[i]} !== 2'b01) begin
                errors++;
                $display("FAIL abc_pop dut%0d: got dv/rdy=%b want 01", i,
                         {digest_valid[i], blk_ready[i]});
            end
        end
    endtask

    task automatic test_two_block();
        run_block(1'b1, 1'b0, BLK_M1, 1'b0, '0);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (lat[i] !== 64 / RPC[i] + 2) begin
                errors++;
                $display("FAIL two_blk1_latency dut%0d: got %0d want %0d", i, lat[i],
                         64 / RPC[i] + 2);
            end
        end
        run_block(1'b0, 1'b1, BLK_M2, 1'b0, '0);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (lat[i] !== 64 / RPC[i] + 2 || rdy_low[i] !== 1'b1) begin
                errors++;
                $display("FAIL two_blk2_latency dut%0d: got %0d (rdy_low %0d) want %0d", i,
                         lat[i], rdy_low[i], 64 / RPC[i] + 2);
            end
            vectors++;
            if (digest[i] !== DIG_TWO) begin
                errors++;
                $display("FAIL two_digest dut%0d: got %h want %h", i, digest[i], DIG_TWO);
            end
        end
        pop_digest();
    endtask

    // Digest held with back-pressure while a new block is offered; nothing may move.
    task automatic test_hold();
        int good [ND];
        run_block(1'b1, 1'b1, BLK_EMPTY, 1'b0, '0);
        for (int i = 0; i < ND; i++) good[i] = 0;
        blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
        for (int w = 0; w < 16; w++) blk_data[32 * w +: 32] = $urandom();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < ND; i++) begin
                if (digest[i] === DIG_EMPTY && digest_valid[i] === 1'b1 && blk_ready[i] === 1'b0)
                    good[i]++;
            end
        end
        blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (good[i] !== 10) begin
                errors++;
                $display("FAIL hold_stable dut%0d: got %0d stable cycles want 10", i, good[i]);
            end
        end
        pop_digest();
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if ({digest_valid[i], blk_ready[i], busy[i]} !== 3'b010) begin
                errors++;
                $display("FAIL hold_pop dut%0d: got dv/rdy/busy=%b want 010", i,
                         {digest_valid[i], blk_ready[i], busy[i]});
            end
        end
    endtask

    task automatic test_midstate();
        logic [255:0] h1;
        logic [255:0] exp;
        logic [255:0] junk;
        h1 = compress(IV, BLK_M1);
        run_block(1'b1, 1'b0, BLK_M1, 1'b0, '0);
        run_block(1'b1, 1'b1, BLK_M2, 1'b1, h1);
        for (int i = 0; i < ND; i++) begin
            exp = MIDS[i] ? DIG_TWO : compress(IV, BLK_M2);
            vectors++;
            if (digest[i] !== exp) begin
                errors++;
                $display("FAIL midstate dut%0d: got %h want %h", i, digest[i], exp);
            end
        end
        pop_digest();
        for (int w = 0; w < 8; w++) junk[32 * w +: 32] = $urandom();
        run_block(1'b1, 1'b0, BLK_M1, 1'b0, '0);
        run_block(1'b0, 1'b1, BLK_M2, 1'b1, junk);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (digest[i] !== DIG_TWO) begin
                errors++;
                $display("FAIL sel_not_first dut%0d: got %h want %h", i, digest[i], DIG_TWO);
            end
        end
        pop_digest();
    endtask

    task automatic test_reset_mid();
        blk_data = BLK_ABC; blk_first = 1'b1; blk_last = 1'b1; iv_sel = 1'b0;
        blk_valid = 1'b1;
        for (int k = 0; k < 300 && blk_ready != '1; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if ({blk_ready[i], digest_valid[i], busy[i]} !== 3'b100 || digest[i] !== 256'h0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: got rdy/dv/busy=%b digest=%h want 100/0",
                         i, {blk_ready[i], digest_valid[i], busy[i]}, digest[i]);
            end
            mh[i] = IV;
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        // Non-first block straight after reset must chain from the FIPS IV.
        run_block(1'b0, 1'b1, BLK_ABC, 1'b0, '0);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (digest[i] !== DIG_ABC) begin
                errors++;
                $display("FAIL midreset_resend dut%0d: got %h want %h", i, digest[i], DIG_ABC);
            end
        end
        pop_digest();
    endtask

    task automatic test_first_mid();
        logic [255:0] exp;
        exp = compress(IV, BLK_M2);
        run_block(1'b1, 1'b0, BLK_M1, 1'b0, '0);
        run_block(1'b1, 1'b1, BLK_M2, 1'b0, '0);
        for (int i = 0; i < ND; i++) begin
            vectors++;
            if (digest[i] !== exp) begin
                errors++;
                $display("FAIL first_abandon dut%0d: got %h want %h", i, digest[i], exp);
            end
        end
        pop_digest();
    endtask

    task automatic test_random();
        int           nb;
        bit           first;
        bit           sel;
        logic [511:0] d;
        logic [255:0] iv;
        for (int m = 0; m < 6; m++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) d[32 * w +: 32] = $urandom();
                for (int w = 0; w < 8; w++) iv[32 * w +: 32] = $urandom();
                first = ($urandom_range(0, 3) != 0);
                sel   = ($urandom_range(0, 1) == 1);
                run_block(first, b == nb - 1, d, sel, iv);
                for (int i = 0; i < ND; i++) begin
                    vectors++;
                    if (lat[i] !== 64 / RPC[i] + 2) begin
                        errors++;
                        $display("FAIL rand_latency msg%0d blk%0d dut%0d: got %0d want %0d",
                                 m, b, i, lat[i], 64 / RPC[i] + 2);
                    end
                end
            end
            for (int i = 0; i < ND; i++) begin
                vectors++;
                if (digest[i] !== mh[i]) begin
                    errors++;
                    $display("FAIL rand_digest msg%0d dut%0d: got %h want %h", m, i, digest[i],
                             mh[i]);
                end
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            pop_digest();
        end
    endtask

    initial begin
        reset_n = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        iv_sel = 1'b0; digest_ready = 1'b0; blk_data = '0; iv_in = '0;
        test_reset();
        test_abc();
        test_two_block();
        test_hold();
        test_midstate();
        test_reset_mid();
        test_first_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Parametrised SHA-256 compression engine for the uPcoin datapath: accepts 512-bit message blocks over a valid/ready stream, chains intermediate hash values across blocks of one message, and presents the final 256-bit digest on a valid/ready output. It is the successor to the single-round-per-cycle core. It adds three things:
- configurable rounds per clock;
- an optional caller-supplied initial hash (midstate), used for mining;
- explicit first/last block framing in place of level-sensitive load strobes.

It sits between the SPI block deserialiser and the uPcoin controller.

## Interface
Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4; any other value is an elaboration error.
- MIDSTATE_EN, 0, when 1, `iv_sel` and `iv_in` are honoured; when 0 the FIPS 180-4 IV is always used.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  block offered.
- blk_ready  out  1  core can accept a block.
- blk_data  in  512  message block; word W0 = [511:480], W15 = [31:0].
- blk_first  in  1  block starts a new message; qualified by blk_valid.
- blk_last  in  1  block ends the message; qualified by blk_valid.
- iv_sel  in  1  with blk_first, use `iv_in` instead of the FIPS IV.
- iv_in  in  256  caller-supplied initial hash, H0 = [255:224].
- digest_valid  out  1  digest available.
- digest_ready  in  1  consumer takes the digest.
- digest  out  256  final hash, H0 = [255:224].
- busy  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → ROUND on block handshake.
  - ROUND → FINAL on the last round cycle.
  - FINAL → OUT if the block was last, else → IDLE.
  - OUT → IDLE on digest handshake.
- IDLE:
  - `blk_ready`=1.
  - On `blk_valid`&`blk_ready`: latch W[0..15] from `blk_data` and `blk_last` into `last_q`.
  - Chain value H for this block:
    - if `blk_first`: H = `iv_in` when `iv_sel`&MIDSTATE_EN, otherwise the FIPS IV;
    - if not `blk_first`: keep the current H.
  - Load a..h from that same chain value H.
  - Set round counter t=0.
- ROUND:
  - Each cycle applies ROUNDS_PER_CYCLE rounds t..t+R-1.
  - K_t comes from the package constant table.
  - W_t comes from a 16-word sliding window. The window shifts by R words per cycle and appends σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16] for each new word.
  - t increments by R; the state exits when t+R = 64.
- FINAL:
  - H_i ← H_i + working var i, mod 2^32 per word. All additions are 32-bit and wrap.
  - If `last_q`: `digest` ← the new H, go to OUT.
  - Otherwise go to IDLE; H is retained for the next block.
- OUT:
  - `digest_valid`=1; `digest` holds stable.
  - On `digest_ready`, go to IDLE.
  - The last H is retained, so a following non-first block continues the chain.
- Boundary conditions:
  - `blk_valid` outside IDLE is ignored, since `blk_ready`=0; offered data must stay stable until accepted.
  - `blk_first` in the middle of a message abandons the previous chain without error.
  - `blk_first`&`blk_last` together means a single-block message.
  - A non-first block right after reset chains from the FIPS IV, because reset loads H with the IV.
  - `iv_sel` is ignored when MIDSTATE_EN=0 or when `blk_first`=0.
  - `digest_ready` outside OUT has no effect.
- Reset (asynchronous, any state, including mid-ROUND):
  - state=IDLE, t=0, H=FIPS IV, `digest`=0.
  - `blk_ready`=1, `digest_valid`=0, `busy`=0.
  - The in-flight block is discarded.

## Timing
- Let N = 64/ROUNDS_PER_CYCLE, i.e. 64, 32 or 16 ROUND cycles.
- Block accepted at edge 0:
  - ROUND occupies edges 1..N;
  - FINAL at edge N+1;
  - then either `digest_valid`=1 after edge N+2, or `blk_ready`=1 again after edge N+2.
- Per-block throughput is N+2 cycles. Single-block latency from acceptance to `digest_valid` is N+2; for R=1 that is 66.
- `digest_valid` drops on the cycle following the edge where `digest_ready` was sampled high.
- The next block can be accepted one cycle later, in IDLE.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Structure
- Package `upcoin_sha_pkg`:
  - state enum;
  - SHA256_IV (256-bit localparam);
  - SHA256_K (64×32 localparam array), replacing file-based constant loading;
  - functions for Ch, Maj, Σ0, Σ1, σ0, σ1.
- Sub-module `sha256_round`: one combinational round, taking a..h, W_t and K_t and producing the new a..h. Instantiate it ROUNDS_PER_CYCLE times in a generate chain.

## Test plan
1. R=1: single block "abc", padded, `blk_first`=`blk_last`=1 → `digest` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad with `digest_valid` exactly 66 cycles after acceptance.
2. R=1, 2 and 4: two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; latency is N+2 per block and `blk_ready` stays low during each block.
3. Empty-message padded block → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; hold `digest_ready`=0 for 10 cycles → `digest` stable and `blk_ready`=0 throughout.
4. MIDSTATE_EN=1:
   - Run block 1 of test 2 with `blk_last`=0 and capture H via a white-box probe.
   - Restart with `iv_sel`=1, `iv_in`=that H, and block 2 marked first and last → the test 2 digest.
   - Repeat with MIDSTATE_EN=0 → the `iv_sel` setting is ignored and the result is the FIPS-IV hash of block 2 alone.
5. Pulse `reset_n` low at t=30 of "abc" → outputs return to their reset values immediately. Then resend "abc" → the correct digest, with no residue from the aborted block.
6. Issue `blk_first` while a two-block message is pending, i.e. after block 1 → block 2 is treated as a new message and the result equals its single-block hash from the FIPS IV.
